// File: rtl/lane_car_counter_if.sv
// Lane counter bus: arrival sensors and green mask in,
// per-lane queue counts, overflow flags and total out.
interface lane_car_counter_if #(
  parameter int NUM_LANES = 8,
  parameter int COUNT_W   = 8
);
  logic [NUM_LANES-1:0]              arriveSensor;
  logic [NUM_LANES-1:0]              laneOutput;
  logic                              clearOverflow;
  logic [NUM_LANES-1:0][COUNT_W-1:0] carCounts;
  logic [NUM_LANES-1:0]              overflowFlag;
  logic [COUNT_W+2:0]                totalCars;

  modport master (
    output arriveSensor,
    output laneOutput,
    output clearOverflow,
    input  carCounts,
    input  overflowFlag,
    input  totalCars
  );

  modport slave (
    input  arriveSensor,
    input  laneOutput,
    input  clearOverflow,
    output carCounts,
    output overflowFlag,
    output totalCars
  );
endinterface

// File: rtl/lane_car_counter.sv
// Per-lane saturating queue counter: sensor rising edges arrive,
// green lanes drain one car every DEPART_INTERVAL cycles.
module lane_car_counter #(
  parameter int NUM_LANES       = 8,
  parameter int COUNT_W         = 8,
  parameter int DEPART_INTERVAL = 4
) (
  input  logic               clk,
  input  logic               rst,
  lane_car_counter_if.slave  bus
);

  localparam int TMR_W =
    (DEPART_INTERVAL > 1) ? $clog2(DEPART_INTERVAL) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST =
    TMR_W'(DEPART_INTERVAL - 1);
  localparam logic [COUNT_W-1:0] CNT_MAX = '1;

  logic [NUM_LANES-1:0]              sensorQ;
  logic [NUM_LANES-1:0][TMR_W-1:0]   departTmr;
  logic [NUM_LANES-1:0][COUNT_W-1:0] countQ;
  logic [NUM_LANES-1:0]              ovfQ;

  logic [NUM_LANES-1:0] arrive;
  logic [NUM_LANES-1:0] tmrWrap;
  logic [NUM_LANES-1:0] depart;
  logic [NUM_LANES-1:0] incr;
  logic [NUM_LANES-1:0] decr;
  logic [NUM_LANES-1:0] ovfSet;
  logic [COUNT_W+2:0]   sum;

  always_comb begin
    arrive  = bus.arriveSensor & ~sensorQ;
    tmrWrap = '0;
    depart  = '0;
    incr    = '0;
    decr    = '0;
    ovfSet  = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      tmrWrap[i] = bus.laneOutput[i] &&
                   (departTmr[i] == TMR_LAST);
      // Timer keeps wrapping on an empty lane; only the pulse is gated.
      depart[i]  = tmrWrap[i] && (countQ[i] != '0);
      incr[i]    = arrive[i] && !depart[i] &&
                   (countQ[i] != CNT_MAX);
      decr[i]    = depart[i] && !arrive[i];
      ovfSet[i]  = arrive[i] && !depart[i] &&
                   (countQ[i] == CNT_MAX);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sensorQ   <= '0;
      departTmr <= '0;
      countQ    <= '0;
      ovfQ      <= '0;
    end else begin
      sensorQ <= bus.arriveSensor;
      for (int i = 0; i < NUM_LANES; i++) begin
        if (!bus.laneOutput[i] || tmrWrap[i])
          departTmr[i] <= '0;
        else
          departTmr[i] <= departTmr[i] + 1'b1;

        unique case (1'b1)
          incr[i]: countQ[i] <= countQ[i] + 1'b1;
          decr[i]: countQ[i] <= countQ[i] - 1'b1;
          default: ;
        endcase

        if (ovfSet[i])
          ovfQ[i] <= 1'b1;
        else if (bus.clearOverflow)
          ovfQ[i] <= 1'b0;
      end
    end
  end

  always_comb begin
    sum = '0;
    for (int i = 0; i < NUM_LANES; i++)
      sum = sum + (COUNT_W+3)'(countQ[i]);
  end

  assign bus.carCounts    = countQ;
  assign bus.overflowFlag = ovfQ;
  assign bus.totalCars    = sum;

endmodule

// File: tb/tb_lane_car_counter.sv
// Directed bench for lane_car_counter with default parameters
// (8 lanes, 8-bit counts, DEPART_INTERVAL=4).
module tb_lane_car_counter;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  lane_car_counter_if #(.NUM_LANES(8), .COUNT_W(8)) bus ();

  lane_car_counter #(
    .NUM_LANES(8),
    .COUNT_W(8),
    .DEPART_INTERVAL(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus.arriveSensor  = '0;
    bus.laneOutput    = '0;
    bus.clearOverflow = 1'b0;
    rst = 1'b0;
    #2;
    rst = 1'b1;
  endtask

  task automatic arrive(input logic [7:0] mask, input int n);
    for (int k = 0; k < n; k++) begin
      bus.arriveSensor = mask;
      tick();
      bus.arriveSensor = '0;
      tick();
    end
  endtask

  task automatic test_reset();
    bus.arriveSensor  = '0;
    bus.laneOutput    = '0;
    bus.clearOverflow = 1'b0;
    rst = 1'b1;
    #1;
    rst = 1'b0;
    #1;
    checks++;
    if (bus.carCounts !== 64'h0) begin
      errors++;
      $display("FAIL reset_counts: got %h expected 0", bus.carCounts);
    end
    checks++;
    if (bus.overflowFlag !== 8'h00) begin
      errors++;
      $display("FAIL reset_flags: got %h expected 0", bus.overflowFlag);
    end
    checks++;
    if (bus.totalCars !== 11'd0) begin
      errors++;
      $display("FAIL reset_total: got %0d expected 0", bus.totalCars);
    end
    // Sensors high while reset is held must not count.
    bus.arriveSensor = 8'hFF;
    tick();
    checks++;
    if (bus.carCounts !== 64'h0) begin
      errors++;
      $display("FAIL reset_hold: got %h expected 0", bus.carCounts);
    end
    bus.arriveSensor = '0;
  endtask

  task automatic test_single_arrival();
    rst = 1'b1;
    bus.arriveSensor = 8'h10;
    tick();
    checks++;
    if (bus.carCounts[4] !== 8'd1) begin
      errors++;
      $display("FAIL arrival_latency: got %0d expected 1",
               bus.carCounts[4]);
    end
    tick();
    tick();
    bus.arriveSensor = '0;
    tick();
    checks++;
    if (bus.carCounts !== 64'h0000_0001_0000_0000) begin
      errors++;
      $display("FAIL arrival_once: got %h expected lane4=1",
               bus.carCounts);
    end
    checks++;
    if (bus.totalCars !== 11'd1) begin
      errors++;
      $display("FAIL arrival_total: got %0d expected 1", bus.totalCars);
    end
    checks++;
    if (bus.overflowFlag !== 8'h00) begin
      errors++;
      $display("FAIL arrival_flags: got %h expected 0", bus.overflowFlag);
    end
  endtask

  task automatic test_green_drain();
    logic [7:0] exp;
    do_reset();
    arrive(8'h01, 3);
    bus.laneOutput = 8'h01;
    for (int g = 1; g <= 14; g++) begin
      tick();
      exp = (g < 4) ? 8'd3 : (g < 8) ? 8'd2 : (g < 12) ? 8'd1 : 8'd0;
      checks++;
      if (bus.carCounts[0] !== exp) begin
        errors++;
        $display("FAIL drain_edge%0d: got %0d expected %0d",
                 g, bus.carCounts[0], exp);
      end
    end
    bus.laneOutput = '0;
  endtask

  task automatic test_simultaneous();
    do_reset();
    arrive(8'h04, 5);
    bus.laneOutput = 8'h04;
    tick();
    tick();
    tick();
    bus.arriveSensor = 8'h04;
    tick();
    checks++;
    if (bus.carCounts[2] !== 8'd5) begin
      errors++;
      $display("FAIL simul_cancel: got %0d expected 5", bus.carCounts[2]);
    end
    bus.arriveSensor = '0;
    tick();
    bus.arriveSensor = 8'h04;
    tick();
    checks++;
    if (bus.carCounts[2] !== 8'd6) begin
      errors++;
      $display("FAIL simul_next: got %0d expected 6", bus.carCounts[2]);
    end
    bus.arriveSensor = '0;
    bus.laneOutput   = '0;
    tick();
  endtask

  task automatic test_saturation();
    do_reset();
    arrive(8'h80, 255);
    checks++;
    if (bus.carCounts[7] !== 8'd255 || bus.overflowFlag !== 8'h00) begin
      errors++;
      $display("FAIL sat_255: got cnt=%0d flg=%h expected 255 00",
               bus.carCounts[7], bus.overflowFlag);
    end
    arrive(8'h80, 1);
    checks++;
    if (bus.carCounts[7] !== 8'd255 || bus.overflowFlag !== 8'h80) begin
      errors++;
      $display("FAIL sat_256: got cnt=%0d flg=%h expected 255 80",
               bus.carCounts[7], bus.overflowFlag);
    end
    checks++;
    if (bus.totalCars !== 11'd255) begin
      errors++;
      $display("FAIL sat_total: got %0d expected 255", bus.totalCars);
    end
    bus.clearOverflow = 1'b1;
    tick();
    bus.clearOverflow = 1'b0;
    checks++;
    if (bus.carCounts[7] !== 8'd255 || bus.overflowFlag !== 8'h00) begin
      errors++;
      $display("FAIL sat_clear: got cnt=%0d flg=%h expected 255 00",
               bus.carCounts[7], bus.overflowFlag);
    end
    bus.arriveSensor  = 8'h80;
    bus.clearOverflow = 1'b1;
    tick();
    bus.arriveSensor  = '0;
    bus.clearOverflow = 1'b0;
    checks++;
    if (bus.carCounts[7] !== 8'd255 || bus.overflowFlag !== 8'h80) begin
      errors++;
      $display("FAIL sat_set_wins: got cnt=%0d flg=%h expected 255 80",
               bus.carCounts[7], bus.overflowFlag);
    end
    tick();
  endtask

  task automatic test_green_interrupt();
    logic [7:0] exp;
    do_reset();
    arrive(8'h20, 4);
    bus.laneOutput = 8'h20;
    tick();
    tick();
    tick();
    bus.laneOutput = '0;
    tick();
    checks++;
    if (bus.carCounts[5] !== 8'd4) begin
      errors++;
      $display("FAIL intr_first: got %0d expected 4", bus.carCounts[5]);
    end
    bus.laneOutput = 8'h20;
    for (int g = 1; g <= 4; g++) begin
      tick();
      exp = (g < 4) ? 8'd4 : 8'd3;
      checks++;
      if (bus.carCounts[5] !== exp) begin
        errors++;
        $display("FAIL intr_edge%0d: got %0d expected %0d",
                 g, bus.carCounts[5], exp);
      end
    end
    bus.laneOutput = '0;
  endtask

  task automatic test_async_reset();
    logic [7:0] m;
    do_reset();
    for (int k = 0; k < 127; k++) begin
      m = 8'h10;
      if (k < 7) m[0] = 1'b1;
      if (k < 8) m[2] = 1'b1;
      arrive(m, 1);
    end
    checks++;
    if (bus.carCounts !== 64'h0000_007F_0008_0007) begin
      errors++;
      $display("FAIL preload: got %h expected 7f/08/07", bus.carCounts);
    end
    bus.laneOutput = 8'h15;
    for (int g = 0; g < 4; g++) tick();
    checks++;
    if (bus.totalCars !== 11'd139) begin
      errors++;
      $display("FAIL drain_total: got %0d expected 139", bus.totalCars);
    end
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if (bus.carCounts !== 64'h0 || bus.totalCars !== 11'd0) begin
      errors++;
      $display("FAIL async_rst: got %h/%0d expected 0/0",
               bus.carCounts, bus.totalCars);
    end
    checks++;
    if (bus.overflowFlag !== 8'h00) begin
      errors++;
      $display("FAIL async_flags: got %h expected 0", bus.overflowFlag);
    end
    bus.laneOutput = '0;
    rst = 1'b1;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_single_arrival();
    test_green_drain();
    test_simultaneous();
    test_saturation();
    test_green_interrupt();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
